elementwise_mult_lanes: RTL and testbench

ELEMENTWISE_MULT_LANES -- requirements
Module: elementwise_mult_lanes

---
 rtl/elementwise_mult_lanes.sv | 103 ++++++++++
 tb/tb_elementwise_mult_lanes.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/elementwise_mult_lanes.sv
// Element-wise vector multiplier: M products computed L per cycle by a small
// IDLE/RUN/DONE sequencer over operands captured at start.
module elementwise_mult_lanes #(
  parameter int N      = 8,
  parameter int M      = 4,
  parameter int L      = 1,
  parameter int SIGNED = 0,
  parameter int CW     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [M*N-1:0]   a,
  input  logic [M*N-1:0]   b,
  output logic [M*2*N-1:0] result,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    cycle_count
);

  localparam int NB = M / L;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int IW = (M > 1) ? $clog2(M) : 1;
  localparam logic [BW-1:0] LAST = BW'(NB - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  logic [BW-1:0]  batch;
  logic [N-1:0]   op_a [M];
  logic [N-1:0]   op_b [M];
  logic [2*N-1:0] res  [M];
  logic [IW-1:0]  lane_idx  [L];
  logic [2*N-1:0] lane_prod [L];

  // Operands are widened to 2N bits (sign- or zero-extended); the low 2N bits
  // of the product are then exact for both signed and unsigned modes.
  for (genvar gi = 0; gi < L; gi++) begin : g_lane
    logic [2*N-1:0] xa;
    logic [2*N-1:0] xb;
    assign lane_idx[gi]  = IW'(int'(batch) * L + gi);
    assign xa = {{N{(SIGNED != 0) && op_a[lane_idx[gi]][N-1]}}, op_a[lane_idx[gi]]};
    assign xb = {{N{(SIGNED != 0) && op_b[lane_idx[gi]][N-1]}}, op_b[lane_idx[gi]]};
    assign lane_prod[gi] = xa * xb;
  end

  for (genvar gi = 0; gi < M; gi++) begin : g_pack
    assign result[gi*2*N +: 2*N] = res[gi];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      batch       <= '0;
      cycle_count <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      for (int i = 0; i < M; i++) begin
        op_a[i] <= '0;
        op_b[i] <= '0;
        res[i]  <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            for (int i = 0; i < M; i++) begin
              op_a[i] <= a[i*N +: N];
              op_b[i] <= b[i*N +: N];
            end
            batch       <= '0;
            cycle_count <= '0;
            busy        <= 1'b1;
            state       <= RUN;
          end
        end
        RUN: begin
          for (int j = 0; j < L; j++) begin
            res[lane_idx[j]] <= lane_prod[j];
          end
          batch       <= batch + BW'(1);
          cycle_count <= cycle_count + CW'(1);
          if (batch == LAST) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_elementwise_mult_lanes.sv
// Scoreboard bench: four instances (L=1, L=2, L=4, signed L=1) sharing clock,
// reset and operands; one monitor checks every done pulse against a queue.
module tb_elementwise_mult_lanes;

  typedef struct {
    int          dut;
    logic [63:0] res;
    logic [7:0]  cnt;
    int          dcyc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [3:0]  start_v;
  logic [31:0] a;
  logic [31:0] b;
  logic [63:0] res_w [4];
  logic [7:0]  cnt_w [4];
  logic [3:0]  busy_w;
  logic [3:0]  done_w;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t sb[$];
  int   nb_v[4]       = '{4, 2, 1, 4};
  int   busy_run[4]   = '{0, 0, 0, 0};

  localparam logic [31:0] A_BASIC   = {8'd4, 8'd3, 8'd2, 8'd1};
  localparam logic [31:0] B_BASIC   = {8'd8, 8'd7, 8'd6, 8'd5};
  localparam logic [63:0] RES_BASIC = {16'd32, 16'd21, 16'd12, 16'd5};

  elementwise_mult_lanes #(.N(8), .M(4), .L(1), .SIGNED(0), .CW(8)) u_l1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a), .b(b),
    .result(res_w[0]), .busy(busy_w[0]), .done(done_w[0]), .cycle_count(cnt_w[0]));
  elementwise_mult_lanes #(.N(8), .M(4), .L(2), .SIGNED(0), .CW(8)) u_l2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a), .b(b),
    .result(res_w[1]), .busy(busy_w[1]), .done(done_w[1]), .cycle_count(cnt_w[1]));
  elementwise_mult_lanes #(.N(8), .M(4), .L(4), .SIGNED(0), .CW(8)) u_l4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a(a), .b(b),
    .result(res_w[2]), .busy(busy_w[2]), .done(done_w[2]), .cycle_count(cnt_w[2]));
  elementwise_mult_lanes #(.N(8), .M(4), .L(1), .SIGNED(1), .CW(8)) u_sg (
    .clk(clk), .rst_n(rst_n), .start(start_v[3]), .a(a), .b(b),
    .result(res_w[3]), .busy(busy_w[3]), .done(done_w[3]), .cycle_count(cnt_w[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, expv);
    end
  endtask

  // Monitor: pops the oldest expectation of the instance raising done.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int d = 0; d < 4; d++) busy_run[d] = 0;
      end else begin
        for (int d = 0; d < 4; d++) begin
          if (busy_w[d]) begin
            busy_run[d]++;
          end else if (busy_run[d] != 0) begin
            chk($sformatf("busy_len%0d", d), 64'(busy_run[d]), 64'(nb_v[d] + 1));
            busy_run[d] = 0;
          end
          if (done_w[d]) begin
            int idx = -1;
            for (int i = 0; i < sb.size(); i++)
              if (idx < 0 && sb[i].dut == d) idx = i;
            if (idx < 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_done%0d: got done=1 at cycle %0d expected none", d, cyc);
            end else begin
              chk($sformatf("result%0d", d), res_w[d], sb[idx].res);
              chk($sformatf("count%0d", d), 64'(cnt_w[d]), 64'(sb[idx].cnt));
              chk($sformatf("done_cycle%0d", d), 64'(cyc), 64'(sb[idx].dcyc));
              $display("op dut%0d result=%h count=%0d cycle=%0d", d, res_w[d], cnt_w[d], cyc);
              sb.delete(idx);
            end
          end
        end
      end
    end
  end

  task automatic issue(input int d, input logic [31:0] av, input logic [31:0] bv,
                       input logic [63:0] expr);
    exp_t e;
    @(negedge clk);
    a = av;
    b = bv;
    start_v[d] = 1'b1;
    @(posedge clk);
    #1;
    e.dut  = d;
    e.res  = expr;
    e.cnt  = 8'(nb_v[d]);
    e.dcyc = cyc + nb_v[d];
    sb.push_back(e);
    @(negedge clk);
    start_v[d] = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d pending ops expected 0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst_n   = 1'b0;
    start_v = 4'b0;
    a       = '0;
    b       = '0;
    #12;
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("rst_result%0d", d), res_w[d], 64'h0);
      chk($sformatf("rst_busy%0d", d), 64'(busy_w[d]), 64'h0);
      chk($sformatf("rst_done%0d", d), 64'(done_w[d]), 64'h0);
      chk($sformatf("rst_count%0d", d), 64'(cnt_w[d]), 64'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Basic multiply on all three lane configurations
    issue(0, A_BASIC, B_BASIC, RES_BASIC);
    wait_idle();
    chk("hold_result", res_w[0], RES_BASIC);
    chk("hold_count", 64'(cnt_w[0]), 64'd4);
    issue(1, A_BASIC, B_BASIC, RES_BASIC);
    issue(2, A_BASIC, B_BASIC, RES_BASIC);
    wait_idle();

    // Signed corner cases and unsigned max*max
    issue(3, {8'h00, 8'h7F, 8'h80, 8'hFF}, {8'h05, 8'h80, 8'h80, 8'hFF},
          {16'h0000, 16'hC080, 16'h4000, 16'h0001});
    issue(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFE01_FE01_FE01_FE01);
    wait_idle();

    // Unwritten elements keep the previous operation's values
    issue(0, A_BASIC, B_BASIC, RES_BASIC);
    @(posedge clk);
    #1;
    chk("partial_write", res_w[0], {16'hFE01, 16'hFE01, 16'hFE01, 16'd5});
    wait_idle();

    // Operand changes and start during RUN are ignored
    issue(0, 32'h0504_0302, 32'h0A0A_0A0A, {16'd50, 16'd40, 16'd30, 16'd20});
    a = 32'hFFFF_FFFF;
    b = 32'hFFFF_FFFF;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_idle();

    // Asynchronous reset in the second RUN cycle aborts the operation
    issue(0, A_BASIC, B_BASIC, RES_BASIC);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].dut == 0) sb.delete(i);
    chk("abort_result", res_w[0], 64'h0);
    chk("abort_busy", 64'(busy_w[0]), 64'h0);
    chk("abort_done", 64'(done_w[0]), 64'h0);
    chk("abort_count", 64'(cnt_w[0]), 64'h0);
    @(posedge clk);
    #1;
    chk("abort_busy_held", 64'(busy_w[0]), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    issue(0, A_BASIC, B_BASIC, RES_BASIC);
    wait_idle();

    // start held for 20 edges: accepts every M/L+2 = 6 cycles
    @(negedge clk);
    a = A_BASIC;
    b = B_BASIC;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_t e;
      e.dut  = 0;
      e.res  = RES_BASIC;
      e.cnt  = 8'd4;
      e.dcyc = cyc + 6 * k + 4;
      sb.push_back(e);
    end
    repeat (19) @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_idle();
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
